// File: rtl/bus_port_endpoint.sv
// bus_port_endpoint: device-side endpoint of one generator/arbiter bus port.
//   TX FIFO : host writes (tx_wr/tx_data, tx_full); bus pops (pndng/pop/D_pop).
//   RX FIFO : bus pushes (push/D_push), filtered on dest ID = D_push[MSB -: 8];
//             host drains (rx_rd/rx_data/rx_pndng/rx_level).
//   Status  : err_flags = sticky {misroute, underflow, overflow};
//             drop_cnt / misr_cnt = saturating RX overflow-drop / misroute counts.
// Both FIFOs are first-word-fall-through with a zeroed head when empty.
// Pointers are binary with one extra wrap bit.
module bus_port_endpoint #(
  parameter int         pckg_sz   = 32,
  parameter int         depth     = 16,
  parameter logic [7:0] my_id     = 8'h00,
  parameter logic [7:0] broadcast = 8'hFF,
  parameter int         cnt_w     = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  output logic                      pndng,
  output logic [pckg_sz-1:0]        D_pop,
  input  logic                      pop,
  input  logic                      push,
  input  logic [pckg_sz-1:0]        D_push,
  input  logic                      tx_wr,
  input  logic [pckg_sz-1:0]        tx_data,
  output logic                      tx_full,
  input  logic                      rx_rd,
  output logic [pckg_sz-1:0]        rx_data,
  output logic                      rx_pndng,
  output logic [$clog2(depth):0]    rx_level,
  output logic [2:0]                err_flags,
  output logic [cnt_w-1:0]          drop_cnt,
  output logic [cnt_w-1:0]          misr_cnt
);

  localparam int AW = $clog2(depth);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0]    PTR_ONE = 1;
  localparam logic [cnt_w-1:0] CNT_ONE = 1;

  logic [pckg_sz-1:0] tx_mem [depth];
  logic [pckg_sz-1:0] rx_mem [depth];

  logic [PW-1:0]    tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [PW-1:0]    rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
  logic [2:0]       err_q, err_d;
  logic [cnt_w-1:0] drop_q, drop_d, misr_q, misr_d;

  logic tx_empty, tx_is_full, tx_do_wr, tx_do_pop;
  logic rx_empty, rx_is_full, rx_do_wr, rx_do_rd;
  logic rx_hit, rx_drop, rx_misr;

  always_comb begin
    tx_empty   = (tx_wr_q == tx_rd_q);
    tx_is_full = (tx_wr_q[AW-1:0] == tx_rd_q[AW-1:0]) && (tx_wr_q[AW] != tx_rd_q[AW]);
    rx_empty   = (rx_wr_q == rx_rd_q);
    rx_is_full = (rx_wr_q[AW-1:0] == rx_rd_q[AW-1:0]) && (rx_wr_q[AW] != rx_rd_q[AW]);

    // A pop in the same cycle frees the slot, so a write to a full FIFO is kept.
    tx_do_pop = pop && !tx_empty;
    tx_do_wr  = tx_wr && (!tx_is_full || tx_do_pop);

    rx_hit    = (D_push[pckg_sz-1 -: 8] == my_id) || (D_push[pckg_sz-1 -: 8] == broadcast);
    rx_misr   = push && !rx_hit;
    rx_do_rd  = rx_rd && !rx_empty;
    rx_do_wr  = push && rx_hit && (!rx_is_full || rx_do_rd);
    rx_drop   = push && rx_hit && !rx_do_wr;

    tx_wr_d = tx_do_wr  ? tx_wr_q + PTR_ONE : tx_wr_q;
    tx_rd_d = tx_do_pop ? tx_rd_q + PTR_ONE : tx_rd_q;
    rx_wr_d = rx_do_wr  ? rx_wr_q + PTR_ONE : rx_wr_q;
    rx_rd_d = rx_do_rd  ? rx_rd_q + PTR_ONE : rx_rd_q;

    err_d = err_q;
    if ((tx_wr && !tx_do_wr) || rx_drop)             err_d[0] = 1'b1;
    if ((pop && tx_empty) || (rx_rd && rx_empty))    err_d[1] = 1'b1;
    if (rx_misr)                                     err_d[2] = 1'b1;

    drop_d = drop_q;
    if (rx_drop && (drop_q != '1)) drop_d = drop_q + CNT_ONE;
    misr_d = misr_q;
    if (rx_misr && (misr_q != '1)) misr_d = misr_q + CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_wr_q <= '0;
      tx_rd_q <= '0;
      rx_wr_q <= '0;
      rx_rd_q <= '0;
      err_q   <= '0;
      drop_q  <= '0;
      misr_q  <= '0;
    end else begin
      tx_wr_q <= tx_wr_d;
      tx_rd_q <= tx_rd_d;
      rx_wr_q <= rx_wr_d;
      rx_rd_q <= rx_rd_d;
      err_q   <= err_d;
      drop_q  <= drop_d;
      misr_q  <= misr_d;
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (!reset && tx_do_wr) tx_mem[tx_wr_q[AW-1:0]] <= tx_data;
    if (!reset && rx_do_wr) rx_mem[rx_wr_q[AW-1:0]] <= D_push;
  end

  always_comb begin
    pndng     = !tx_empty;
    tx_full   = tx_is_full;
    D_pop     = tx_empty ? '0 : tx_mem[tx_rd_q[AW-1:0]];
    rx_pndng  = !rx_empty;
    rx_data   = rx_empty ? '0 : rx_mem[rx_rd_q[AW-1:0]];
    rx_level  = rx_wr_q - rx_rd_q;
    err_flags = err_q;
    drop_cnt  = drop_q;
    misr_cnt  = misr_q;
  end

endmodule

// File: tb/tb_bus_port_endpoint.sv
module tb_bus_port_endpoint;

  logic        clk = 1'b0;
  logic        reset;
  logic        pndng;
  logic [31:0] D_pop;
  logic        pop;
  logic        push;
  logic [31:0] D_push;
  logic        tx_wr;
  logic [31:0] tx_data;
  logic        tx_full;
  logic        rx_rd;
  logic [31:0] rx_data;
  logic        rx_pndng;
  logic [4:0]  rx_level;
  logic [2:0]  err_flags;
  logic [7:0]  drop_cnt;
  logic [7:0]  misr_cnt;

  int checks = 0;
  int errors = 0;

  bus_port_endpoint #(
    .pckg_sz(32), .depth(16), .my_id(8'h00), .broadcast(8'hFF), .cnt_w(8)
  ) dut (
    .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop), .pop(pop),
    .push(push), .D_push(D_push), .tx_wr(tx_wr), .tx_data(tx_data),
    .tx_full(tx_full), .rx_rd(rx_rd), .rx_data(rx_data), .rx_pndng(rx_pndng),
    .rx_level(rx_level), .err_flags(err_flags), .drop_cnt(drop_cnt),
    .misr_cnt(misr_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rx_pat(input int unsigned i);
    return ((i % 2) != 0 ? 32'hFF00_0000 : 32'h0000_0000) | i;
  endfunction

  initial begin
    reset = 1'b1; pop = 1'b0; push = 1'b0; D_push = '0;
    tx_wr = 1'b0; tx_data = '0; rx_rd = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check("rst_pndng", 32'(pndng), 32'd0);
    check("rst_tx_full", 32'(tx_full), 32'd0);
    check("rst_D_pop", D_pop, 32'd0);
    check("rst_rx_data", rx_data, 32'd0);
    check("rst_rx_pndng", 32'(rx_pndng), 32'd0);
    check("rst_rx_level", 32'(rx_level), 32'd0);
    check("rst_err", 32'(err_flags), 32'd0);
    check("rst_drop", 32'(drop_cnt), 32'd0);
    check("rst_misr", 32'(misr_cnt), 32'd0);

    // T1: three writes, FWFT latency of one cycle, in-order pops
    tx_wr = 1'b1; tx_data = 32'hAA00_0001;
    tick();
    check("t1_pndng_lat", 32'(pndng), 32'd1);
    check("t1_head_lat", D_pop, 32'hAA00_0001);
    tx_data = 32'hAA00_0002; tick();
    tx_data = 32'hAA00_0003; tick();
    tx_wr = 1'b0;
    pop = 1'b1;
    check("t1_pop1", D_pop, 32'hAA00_0001); tick();
    check("t1_pop2", D_pop, 32'hAA00_0002); tick();
    check("t1_pop3", D_pop, 32'hAA00_0003); tick();
    pop = 1'b0;
    check("t1_empty_pndng", 32'(pndng), 32'd0);
    check("t1_empty_D_pop", D_pop, 32'd0);
    check("t1_err", 32'(err_flags), 32'd0);

    // T2: fill TX (pointers start at 3 so this wraps), overflow, write+pop on full
    tx_wr = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tx_data = 32'h100 + 32'(i);
      tick();
      if (i == 14) check("t2_not_full_15", 32'(tx_full), 32'd0);
    end
    check("t2_full", 32'(tx_full), 32'd1);
    check("t2_err_before", 32'(err_flags), 32'd0);
    tx_data = 32'hDEAD; tick();
    check("t2_ovf_flag", 32'(err_flags), 32'b001);
    check("t2_ovf_head", D_pop, 32'h100);
    tx_data = 32'h200; pop = 1'b1; tick();
    tx_wr = 1'b0;
    check("t2_wrpop_full", 32'(tx_full), 32'd1);
    check("t2_wrpop_head", D_pop, 32'h101);
    for (int i = 0; i < 16; i++) begin
      check("t2_drain", D_pop, (i < 15) ? 32'h101 + 32'(i) : 32'h200);
      tick();
    end
    pop = 1'b0;
    check("t2_drained", 32'(pndng), 32'd0);

    // T3: RX accept by my_id and broadcast, then a misroute
    push = 1'b1; D_push = 32'h0000_BEEF; tick();
    check("t3_rx_pndng", 32'(rx_pndng), 32'd1);
    check("t3_rx_head", rx_data, 32'h0000_BEEF);
    D_push = 32'hFF00_0001; tick();
    check("t3_level2", 32'(rx_level), 32'd2);
    D_push = 32'h0500_0000; tick();
    push = 1'b0;
    check("t3_misr_cnt", 32'(misr_cnt), 32'd1);
    check("t3_err", 32'(err_flags), 32'b101);
    check("t3_level_kept", 32'(rx_level), 32'd2);
    rx_rd = 1'b1;
    check("t3_rd1", rx_data, 32'h0000_BEEF); tick();
    check("t3_rd2", rx_data, 32'hFF00_0001); tick();
    rx_rd = 1'b0;
    check("t3_rx_empty", 32'(rx_level), 32'd0);

    // T4: RX overflow drops, then push together with rx_rd on full
    push = 1'b1;
    for (int unsigned i = 0; i < 18; i++) begin
      D_push = rx_pat(i);
      tick();
      if (i == 15) check("t4_full_no_drop", 32'(drop_cnt), 32'd0);
    end
    check("t4_level16", 32'(rx_level), 32'd16);
    check("t4_drop2", 32'(drop_cnt), 32'd2);
    D_push = 32'h0000_0099; rx_rd = 1'b1;
    check("t4_head0", rx_data, rx_pat(0));
    tick();
    push = 1'b0;
    check("t4_rdpush_level", 32'(rx_level), 32'd16);
    check("t4_rdpush_drop", 32'(drop_cnt), 32'd2);
    for (int unsigned i = 0; i < 16; i++) begin
      check("t4_drain", rx_data, (i < 15) ? rx_pat(i + 1) : 32'h0000_0099);
      tick();
    end
    rx_rd = 1'b0;
    check("t4_drained", 32'(rx_pndng), 32'd0);

    // T5: underflow on both sides leaves pointers alone
    reset = 1'b1; tick(); reset = 1'b0;
    rx_rd = 1'b1; tick(); rx_rd = 1'b0;
    check("t5_rx_unf_flag", 32'(err_flags), 32'b010);
    check("t5_rx_unf_level", 32'(rx_level), 32'd0);
    pop = 1'b1; tick(); pop = 1'b0;
    check("t5_tx_unf_pndng", 32'(pndng), 32'd0);
    check("t5_tx_unf_flag", 32'(err_flags), 32'b010);
    tx_wr = 1'b1; tx_data = 32'hABC; push = 1'b1; D_push = 32'h0000_0ABD;
    tick();
    tx_wr = 1'b0; push = 1'b0;
    check("t5_tx_after_unf", D_pop, 32'hABC);
    check("t5_rx_after_unf", 32'(rx_level), 32'd1);
    pop = 1'b1; rx_rd = 1'b1;
    check("t5_rx_head", rx_data, 32'h0000_0ABD);
    tick();
    pop = 1'b0; rx_rd = 1'b0;
    check("t5_tx_empty", 32'(pndng), 32'd0);
    check("t5_rx_empty", 32'(rx_pndng), 32'd0);

    // T5: 40 streaming cycles across several pointer wraps
    for (int i = 0; i < 40; i++) begin
      tx_wr = 1'b1; tx_data = 32'h3000 + 32'(i); pop = (i > 0);
      push = 1'b1; D_push = 32'h4000 + 32'(i); rx_rd = (i > 0);
      tick();
      check("t5_wrap_tx", D_pop, 32'h3000 + 32'(i));
      check("t5_wrap_rx", rx_data, 32'h4000 + 32'(i));
      check("t5_wrap_lvl", 32'(rx_level), 32'd1);
    end
    tx_wr = 1'b0; push = 1'b0;
    tick();
    pop = 1'b0; rx_rd = 1'b0;
    check("t5_wrap_tx_end", 32'(pndng), 32'd0);
    check("t5_wrap_rx_end", 32'(rx_level), 32'd0);
    check("t5_wrap_err", 32'(err_flags), 32'b010);

    // Misroute counter saturation
    push = 1'b1; D_push = 32'h1200_0000;
    for (int i = 0; i < 260; i++) tick();
    push = 1'b0;
    check("sat_misr", 32'(misr_cnt), 32'd255);
    check("sat_level", 32'(rx_level), 32'd0);

    // T6: reset mid-operation with 5 entries in each FIFO
    tx_wr = 1'b1; push = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tx_data = 32'h6000 + 32'(i); D_push = 32'h0000_7000 + 32'(i);
      tick();
    end
    check("t6_pre_level", 32'(rx_level), 32'd5);
    check("t6_pre_head", D_pop, 32'h6000);
    reset = 1'b1; tx_data = 32'hBAD; D_push = 32'h0000_0BAD;
    tick();
    reset = 1'b0; tx_wr = 1'b0; push = 1'b0;
    check("t6_pndng", 32'(pndng), 32'd0);
    check("t6_rx_pndng", 32'(rx_pndng), 32'd0);
    check("t6_rx_level", 32'(rx_level), 32'd0);
    check("t6_D_pop", D_pop, 32'd0);
    check("t6_rx_data", rx_data, 32'd0);
    check("t6_misr", 32'(misr_cnt), 32'd0);
    check("t6_drop", 32'(drop_cnt), 32'd0);
    check("t6_err", 32'(err_flags), 32'd0);
    check("t6_tx_full", 32'(tx_full), 32'd0);
    tx_wr = 1'b1; tx_data = 32'h55; tick(); tx_wr = 1'b0;
    check("t6_first_write", D_pop, 32'h55);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
